vbus_sched: RTL

Write scheduler for the shared video register bus (`addr`/`data`/`rw`) that feeds the text buffer (0xFC00–0xFFFF) and sprite registers (0xFBF0–0xFBFF). It accepts register writes from two requesters at any time and buffers each in a small FIFO. It drains the FIFOs onto the bus only while `vsync` is high, using round-robin arbitration and an optional per-frame write budget. It replaces ad-hoc vsync-gated writers so multiple sources can update video state tear-free.

---
 rtl/vbus_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vbus_sched.sv
// vbus_sched
// Write scheduler for the shared video register bus. Two requesters queue
// register writes into private FIFOs at any time; the FIFOs drain onto the
// bus only while vsync is high, one write per cycle, with round-robin
// arbitration and an optional per-window write budget.
//
// Parameters
//   DEPTH      entries per requester FIFO (power of two, >= 2)
//   BUDGET     max bus writes per vsync window, 0 = unlimited
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   vsync                      high = bus writes permitted
//   req{0,1}_valid/ready       push handshake per requester (ready = not full)
//   req{0,1}_addr/data         write address / data offered by the requester
//   addr, data, rw             registered bus outputs; rw=1 is a write strobe
//   busy                       any FIFO holds an entry
//   granted                    requester whose entry is on the bus (when rw=1)
module vbus_sched #(
  parameter int DEPTH  = 4,
  parameter int BUDGET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        rw,
  output logic        busy,
  output logic        granted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   BUDGET_W = 16'(BUDGET);
  // With no budget the counter still saturates so it never wraps.
  localparam logic [15:0]   SENT_MAX = (BUDGET == 0) ? 16'hFFFF : 16'(BUDGET);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t        mem     [2][DEPTH];
  logic [PW-1:0] wr_ptr  [2];
  logic [PW-1:0] rd_ptr  [2];
  logic [CW-1:0] count   [2];
  entry_t        push_entry [2];

  logic [1:0]  push, pop, full, nempty;
  logic        prio, vs_q, rise, elig, under_budget, gnt_idx;
  logic [15:0] sent, sent_eff;
  entry_t      head;

  // ---------------------------------------------------------------------
  // FIFO status and push decode (ready depends on registered count only)
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a value on every path (here via the
  // straight-line assignments, below via defaults) so no latch is inferred.
  always_comb begin
    push_entry[0] = '{addr: req0_addr, data: req0_data};
    push_entry[1] = '{addr: req1_addr, data: req1_data};
    for (int i = 0; i < 2; i++) begin
      full[i]   = (count[i] == FULL_CNT);
      nempty[i] = (count[i] != '0);
    end
    push[0] = req0_valid & ~full[0];
    push[1] = req1_valid & ~full[1];
  end

  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];
  assign busy       = |nempty;

  // ---------------------------------------------------------------------
  // Window tracking, eligibility and round-robin grant
  // ---------------------------------------------------------------------
  always_comb begin
    rise = vsync & ~vs_q;
    // The budget clear on a rising vsync edge takes effect in that same
    // cycle, so a new window can grant in its first cycle even if the
    // previous window exhausted the budget.
    sent_eff     = rise ? '0 : sent;
    under_budget = (BUDGET == 0) || (sent_eff < BUDGET_W);
    elig         = vsync & (|nempty) & under_budget;
    gnt_idx      = (nempty[0] & nempty[1]) ? prio : nempty[1];
    pop          = 2'b00;
    if (elig) pop[gnt_idx] = 1'b1;
    head         = mem[gnt_idx][rd_ptr[gnt_idx]];
  end

  // ---------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= push_entry[i];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bus output register, priority and budget counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q    <= 1'b0;
      prio    <= 1'b0;
      sent    <= '0;
      rw      <= 1'b0;
      addr    <= '0;
      data    <= '0;
      granted <= 1'b0;
    end else begin
      vs_q <= vsync;
      if (elig) begin
        rw      <= 1'b1;
        addr    <= head.addr;
        data    <= head.data;
        granted <= gnt_idx;
        prio    <= ~gnt_idx;
        sent    <= (sent_eff == SENT_MAX) ? sent_eff : sent_eff + 16'd1;
      end else begin
        rw      <= 1'b0;
        addr    <= '0;
        data    <= '0;
        sent    <= sent_eff;
      end
    end
  end

endmodule
